// File: rtl/exe_wb_stage.sv
// rtl/exe_wb_stage.sv - execute/memory/writeback stage FSM; optional MEM_TIMEOUT_EN adds a 15-cycle memory timeout with sticky mem_err
module exe_wb_stage #(
    parameter int ARQ              = 16,
    parameter int MEMORY_ADDR_SIZE = 13
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        id_valid,
    input  logic [ARQ-1:0]              src1_exe_in,
    input  logic [ARQ-1:0]              src2_exe_in,
    input  logic [ARQ-1:0]              src3_exe_in,
    input  logic [ARQ-1:0]              imm_exe_in,
    input  logic [1:0]                  alu_op_exe_in,
    input  logic                        mux_exe_in,
    input  logic                        mux_exe_mem_in,
    input  logic                        wb_en_exe_in,
    input  logic                        rd_en_mem_exe_in,
    input  logic                        wr_en_mem_exe_in,
    input  logic                        jenable_exe_in,
    input  logic                        jop_lsb_exe_in,
    input  logic                        pc_en_exe_in,
    input  logic [MEMORY_ADDR_SIZE-1:0] jaddr_exe_in,
    input  logic [3:0]                  wb_rd_in,
    output logic                        exe_ready,
    output logic [ARQ-1:0]              wb_result,
    output logic [3:0]                  wb_rd_out,
    output logic                        wr_reg_en,
    output logic                        branch_taken,
    output logic [MEMORY_ADDR_SIZE-1:0] jaddr_out,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [MEMORY_ADDR_SIZE-1:0] mem_addr,
    output logic [ARQ-1:0]              mem_wdata,
    input  logic [ARQ-1:0]              mem_rdata,
    input  logic                        mem_ack,
    output logic                        mem_err
);

    typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;

    state_t                        r_state;
    state_t                        w_next;
    logic [ARQ-1:0]                r_src1, r_src2, r_src3, r_imm;
    logic [1:0]                    r_alu_op;
    logic                          r_mux, r_mux_mem, r_wb_en, r_rd_en, r_wr_en;
    logic                          r_jen, r_jop, r_pc_en;
    logic [MEMORY_ADDR_SIZE-1:0]   r_jaddr;
    logic [3:0]                    r_rd;
    logic [ARQ-1:0]                r_rdata;
    logic                          r_exe_ready;
    logic [ARQ-1:0]                r_wb_result;
    logic [3:0]                    r_wb_rd;
    logic [MEMORY_ADDR_SIZE-1:0]   r_jaddr_out;
    logic                          r_wr_reg_en, r_branch;
    logic                          w_accept, w_timeout, w_branch;
    logic [ARQ-1:0]                w_b, w_alu, w_cap_data, w_wb_data;

    // Acceptance is gated by the registered ready so nothing is taken before the first edge after reset
    assign w_accept = r_exe_ready & id_valid;
    assign w_b      = r_mux ? r_imm : r_src2;

    // ALU evaluated from the registered bundle; results wrap modulo 2^ARQ
    always_comb begin
        w_alu = '0;
        case (r_alu_op)
            2'b00:   w_alu = r_src1 + w_b;
            2'b01:   w_alu = r_src1 - w_b;
            2'b10:   w_alu = r_src1 * w_b;
            default: w_alu = r_src1 ^ w_b;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    logic [3:0] r_to_cnt;
    logic       r_mem_err;

    assign w_timeout = (r_state == MEM) && (r_to_cnt == 4'd14) && !mem_ack;
    assign mem_err   = r_mem_err;

    // Timeout counter runs only in MEM; the error flag is sticky until reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_cnt  <= 4'd0;
            r_mem_err <= 1'b0;
        end else begin
            r_to_cnt <= (r_state == MEM) ? r_to_cnt + 4'd1 : 4'd0;
            if (w_timeout)
                r_mem_err <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign mem_err   = 1'b0;
`endif

    // Load data seen at the transition into WB: live on the ack edge, zero on timeout, else last capture
    assign w_cap_data = (r_state == MEM) ? (mem_ack ? mem_rdata : '0) : r_rdata;
    assign w_wb_data  = r_mux_mem ? w_cap_data : w_alu;
    assign w_branch   = r_jen && (!r_jop || (w_alu == '0));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = EXEC;
            EXEC: begin
                if (!r_pc_en)                w_next = IDLE;
                else if (r_rd_en || r_wr_en) w_next = MEM;
                else                         w_next = WB;
            end
            MEM:  if (mem_ack || w_timeout) w_next = WB;
            default: w_next = IDLE;
        endcase
    end

    // Bundle capture on acceptance and load-data capture on ack/timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_src1 <= '0; r_src2 <= '0; r_src3 <= '0; r_imm <= '0;
            r_alu_op <= 2'b00; r_mux <= 1'b0; r_mux_mem <= 1'b0; r_wb_en <= 1'b0;
            r_rd_en <= 1'b0; r_wr_en <= 1'b0; r_jen <= 1'b0; r_jop <= 1'b0;
            r_pc_en <= 1'b0; r_jaddr <= '0; r_rd <= 4'd0; r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_src1 <= src1_exe_in; r_src2 <= src2_exe_in; r_src3 <= src3_exe_in;
                r_imm <= imm_exe_in; r_alu_op <= alu_op_exe_in; r_mux <= mux_exe_in;
                r_mux_mem <= mux_exe_mem_in; r_wb_en <= wb_en_exe_in;
                r_rd_en <= rd_en_mem_exe_in; r_wr_en <= wr_en_mem_exe_in;
                r_jen <= jenable_exe_in; r_jop <= jop_lsb_exe_in; r_pc_en <= pc_en_exe_in;
                r_jaddr <= jaddr_exe_in; r_rd <= wb_rd_in;
            end
            if (r_state == MEM && mem_ack) r_rdata <= mem_rdata;
            else if (w_timeout)            r_rdata <= '0;
        end
    end

    // Ready flag and WB outputs; results load on WB entry and hold otherwise, strobes last one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_exe_ready <= 1'b0;
            r_wb_result <= '0;
            r_wb_rd     <= 4'd0;
            r_jaddr_out <= '0;
            r_wr_reg_en <= 1'b0;
            r_branch    <= 1'b0;
        end else begin
            r_exe_ready <= (w_next == IDLE);
            r_wr_reg_en <= 1'b0;
            r_branch    <= 1'b0;
            if (w_next == WB) begin
                r_wb_result <= w_wb_data;
                r_wb_rd     <= r_rd;
                r_jaddr_out <= r_jaddr;
                r_wr_reg_en <= r_wb_en;
                r_branch    <= w_branch;
            end
        end
    end

    assign exe_ready    = r_exe_ready;
    assign wb_result    = r_wb_result;
    assign wb_rd_out    = r_wb_rd;
    assign jaddr_out    = r_jaddr_out;
    assign wr_reg_en    = r_wr_reg_en;
    assign branch_taken = r_branch;
    assign mem_req      = (r_state == MEM);
    assign mem_we       = (r_state == MEM) && r_wr_en;
    assign mem_addr     = (r_state == MEM) ? w_alu[MEMORY_ADDR_SIZE-1:0] : '0;
    assign mem_wdata    = (r_state == MEM) ? r_src3 : '0;

endmodule

// File: tb/tb_exe_wb_stage.sv
// tb/tb_exe_wb_stage.sv - scoreboard bench for exe_wb_stage with a queue-based reference model
module tb_exe_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        id_valid = 1'b0;
    logic [15:0] src1 = '0, src2 = '0, src3 = '0, imm = '0;
    logic [1:0]  op = '0;
    logic        mx = 0, mxm = 0, wben = 0, rden = 0, wren = 0, jen = 0, jop = 0, pcen = 0;
    logic [12:0] jaddr = '0;
    logic [3:0]  rdi = '0;
    logic        exe_ready, wr_reg_en, branch_taken, mem_req, mem_we, mem_err;
    logic [15:0] wb_result, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [3:0]  wb_rd_out;
    logic [12:0] jaddr_out, mem_addr;

    exe_wb_stage #(.ARQ(16), .MEMORY_ADDR_SIZE(13)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .src1_exe_in(src1), .src2_exe_in(src2), .src3_exe_in(src3), .imm_exe_in(imm),
        .alu_op_exe_in(op), .mux_exe_in(mx), .mux_exe_mem_in(mxm), .wb_en_exe_in(wben),
        .rd_en_mem_exe_in(rden), .wr_en_mem_exe_in(wren), .jenable_exe_in(jen),
        .jop_lsb_exe_in(jop), .pc_en_exe_in(pcen), .jaddr_exe_in(jaddr), .wb_rd_in(rdi),
        .exe_ready(exe_ready), .wb_result(wb_result), .wb_rd_out(wb_rd_out),
        .wr_reg_en(wr_reg_en), .branch_taken(branch_taken), .jaddr_out(jaddr_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] s1, s2, s3, imm;
        logic [1:0]  op;
        bit          mx, mxm, wb, rd_en, wr_en, jen, jop, pc;
        logic [12:0] ja;
        logic [3:0]  rd;
        logic [15:0] rdata;
        int          dly;
    } txn_t;

    typedef struct {
        bit          wr;
        logic [15:0] res;
        logic [3:0]  rd;
        bit          br;
        logic [12:0] ja;
        bit          mem;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [12:0] addr;
        bit          we;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          dly;
    } mem_t;

    exp_t        exp_q[$];
    mem_t        mem_q[$];
    int          vectors = 0;
    int          errors  = 0;
    int          cyc     = 0;
    int          ack_cyc = 0;
    bit          resp_en = 1'b1;
    logic [15:0] last_rdata = '0;
    bit          prev_strobe = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_alu(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        case (o)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    begin p = a * b; return p[15:0]; end
            default: return a ^ b;
        endcase
    endfunction

    // Drive one bundle, then push what the reference model expects from it
    task automatic send(input txn_t t, input bit push);
        int k;
        logic [15:0] r;
        bit mem;
        exp_t e;
        mem_t m;
        int n;
        k = 0;
        @(negedge clk);
        while (!exe_ready && k < 100) begin @(negedge clk); k++; end
        if (!exe_ready) chk("ready_timeout", 32'd0, 32'd1);
        src1 = t.s1; src2 = t.s2; src3 = t.s3; imm = t.imm; op = t.op;
        mx = t.mx; mxm = t.mxm; wben = t.wb; rden = t.rd_en; wren = t.wr_en;
        jen = t.jen; jop = t.jop; pcen = t.pc; jaddr = t.ja; rdi = t.rd;
        id_valid = 1'b1;
        @(posedge clk);
        #1;
        n = cyc;
        id_valid = 1'b0;
        if (push && t.pc) begin
            r   = ref_alu(t.op, t.s1, t.mx ? t.imm : t.s2);
            mem = t.rd_en || t.wr_en;
            e.cyc = n + 1;
            e.mem = 1'b0;
            if (mem && resp_en) begin
                m.addr = r[12:0]; m.we = t.wr_en; m.wdata = t.s3;
                m.rdata = t.rdata; m.dly = t.dly;
                mem_q.push_back(m);
                last_rdata = t.rdata;
                e.mem = 1'b1;
            end else if (mem) begin
                last_rdata = '0;
                e.cyc = n + 16;
            end
            e.wr  = t.wb;
            e.res = t.mxm ? last_rdata : r;
            e.rd  = t.rd;
            e.br  = t.jen && (!t.jop || r == 16'd0);
            e.ja  = t.ja;
            if (e.wr || e.br) exp_q.push_back(e);
        end
    endtask

    // Memory responder: checks each request against the model and acks after the chosen delay
    initial begin
        mem_t m;
        forever begin
            @(negedge clk);
            if (resp_en && rst && mem_req) begin
                if (mem_q.size() == 0) begin
                    chk("unexpected_mem_req", 32'd1, 32'd0);
                    @(negedge clk);
                end else begin
                    m = mem_q.pop_front();
                    chk("mem_addr", {19'd0, mem_addr}, {19'd0, m.addr});
                    chk("mem_we", {31'd0, mem_we}, {31'd0, m.we});
                    chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, m.wdata});
                    for (int i = 0; i < m.dly; i++) begin
                        @(negedge clk);
                        chk("mem_hold", {mem_req, mem_we, 2'b0, mem_addr, mem_wdata},
                                        {1'b1, m.we, 2'b0, m.addr, m.wdata});
                    end
                    mem_rdata = m.rdata;
                    mem_ack   = 1'b1;
                    ack_cyc   = cyc + 1;
                    @(negedge clk);
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                end
            end
        end
    end

    // Writeback/redirect monitor: pops the scoreboard whenever a strobe appears
    initial begin
        exp_t e;
        bit strobe;
        forever begin
            @(negedge clk);
            strobe = wr_reg_en || branch_taken;
            if (rst && strobe) begin
                if (prev_strobe) chk("strobe_one_cycle", 32'd1, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", {30'd0, wr_reg_en, branch_taken}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_reg_en", {31'd0, wr_reg_en}, {31'd0, e.wr});
                    chk("branch_taken", {31'd0, branch_taken}, {31'd0, e.br});
                    chk("latency", cyc, e.mem ? ack_cyc : e.cyc);
                    if (e.wr) begin
                        chk("wb_result", {16'd0, wb_result}, {16'd0, e.res});
                        chk("wb_rd_out", {28'd0, wb_rd_out}, {28'd0, e.rd});
                    end
                    if (e.br) chk("jaddr_out", {19'd0, jaddr_out}, {19'd0, e.ja});
                end
            end
            prev_strobe = rst && strobe;
        end
    end

    function automatic txn_t blank();
        txn_t t;
        t.s1 = 0; t.s2 = 0; t.s3 = 0; t.imm = 0; t.op = 0;
        t.mx = 0; t.mxm = 0; t.wb = 0; t.rd_en = 0; t.wr_en = 0;
        t.jen = 0; t.jop = 0; t.pc = 1; t.ja = 0; t.rd = 0; t.rdata = 0; t.dly = 0;
        return t;
    endfunction

    task automatic chk_all_zero(input string name);
        chk(name, {exe_ready, wr_reg_en, branch_taken, mem_req, mem_we, mem_err, 26'd0}, 32'd0);
        chk(name, {wb_result, wb_rd_out, 12'd0}, 32'd0);
        chk(name, {jaddr_out, mem_addr, 6'd0}, 32'd0);
        chk(name, {16'd0, mem_wdata}, 32'd0);
    endtask

    initial begin
        txn_t t;
        int k;
        #23;
        chk_all_zero("reset_outputs");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {31'd0, exe_ready}, 32'd1);

        // Immediate subtract: 17 - 5
        t = blank(); t.s1 = 17; t.imm = 5; t.mx = 1; t.op = 2'b01; t.wb = 1; t.rd = 3;
        send(t, 1);
        // Load from 0x100 + 4 with a three-cycle ack delay
        t = blank(); t.s1 = 16'h0100; t.imm = 4; t.mx = 1; t.op = 2'b00; t.rd_en = 1;
        t.mxm = 1; t.wb = 1; t.rd = 7; t.rdata = 16'hBEEF; t.dly = 3;
        send(t, 1);
        // Taken-if-zero branch, then the same compare with a nonzero result
        t = blank(); t.s1 = 9; t.s2 = 9; t.op = 2'b01; t.jen = 1; t.jop = 1; t.ja = 13'h1A0;
        send(t, 1);
        t.s2 = 8;
        send(t, 1);
        // Bubble carrying writeback and store enables
        t = blank(); t.pc = 0; t.wb = 1; t.wr_en = 1; t.s1 = 5;
        send(t, 1);
        @(negedge clk);
        chk("bubble_busy", {31'd0, exe_ready}, 32'd0);
        @(negedge clk);
        chk("bubble_ready", {31'd0, exe_ready}, 32'd1);

        // Randomized bundles
        for (int i = 0; i < 60; i++) begin
            t.s1 = $urandom; t.s2 = $urandom; t.s3 = $urandom; t.imm = $urandom;
            t.op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) t.s2 = t.s1;
            t.mx = 1'($urandom); t.mxm = 1'($urandom); t.wb = 1'($urandom);
            t.rd_en = ($urandom_range(0, 2) == 0); t.wr_en = ($urandom_range(0, 2) == 0);
            t.jen = 1'($urandom); t.jop = 1'($urandom); t.pc = ($urandom_range(0, 5) != 0);
            t.ja = 13'($urandom); t.rd = 4'($urandom); t.rdata = $urandom;
            t.dly = $urandom_range(0, 4);
            send(t, 1);
        end
        repeat (30) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 32'd0);
        chk("mem_q_drained", mem_q.size(), 32'd0);
        chk("mem_err_default", {31'd0, mem_err}, 32'd0);

        // Reset while a load is waiting in MEM
        resp_en = 1'b0;
        t = blank(); t.s1 = 16'h0040; t.rd_en = 1; t.wb = 1; t.mxm = 1;
        send(t, 0);
        k = 0;
        while (!mem_req && k < 20) begin @(negedge clk); k++; end
        chk("mid_mem_req_seen", {31'd0, mem_req}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_mem_reset_req", {31'd0, mem_req}, 32'd0);
        chk_all_zero("mid_mem_reset_outputs");
        last_rdata = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", {31'd0, exe_ready}, 32'd1);
        chk("post_reset_outputs", {wb_result, wb_rd_out, wr_reg_en, mem_req, mem_err, 9'd0}, 32'd0);
        resp_en = 1'b1;

`ifdef MEM_TIMEOUT_EN
        // Load that never gets an ack
        resp_en = 1'b0;
        t = blank(); t.s1 = 16'h0020; t.rd_en = 1; t.wb = 1; t.mxm = 1; t.rd = 9;
        send(t, 1);
        repeat (25) @(negedge clk);
        chk("timeout_mem_err", {31'd0, mem_err}, 32'd1);
        resp_en = 1'b1;
        t = blank(); t.s1 = 3; t.s2 = 4; t.wb = 1; t.rd = 2;
        send(t, 1);
        repeat (5) @(negedge clk);
        chk("mem_err_sticky", {31'd0, mem_err}, 32'd1);
        rst = 1'b0;
        #1 chk("mem_err_reset", {31'd0, mem_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
`endif

        chk("final_exp_q", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/exe_wb_stage.md
EXE_WB_STAGE -- requirements
Module: exe_wb_stage

Interface
REQ-001 SHALL have parameters: ARQ, default 16, datapath width; MEMORY_ADDR_SIZE, default 13, memory/jump address width.
REQ-002 SHALL have one clock and an asynchronous active-low reset, fixed as below.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have the decoded-bundle inputs from ID:
- id_valid  in  1  bundle valid.
- src1_exe_in, src2_exe_in, src3_exe_in, imm_exe_in  in  ARQ  operands, store data, immediate.
- alu_op_exe_in  in  2  ALU operation.
- mux_exe_in  in  1  ALU B select: 0 src2, 1 imm.
- mux_exe_mem_in  in  1  writeback select: 0 ALU, 1 memory.
- wb_en_exe_in, rd_en_mem_exe_in, wr_en_mem_exe_in  in  1  writeback, load and store enables.
- jenable_exe_in, jop_lsb_exe_in  in  1  jump enable; 0 unconditional, 1 taken-if-zero.
- pc_en_exe_in  in  1  0 marks the bundle a bubble.
- jaddr_exe_in  in  MEMORY_ADDR_SIZE  jump target.
- wb_rd_in  in  4  destination register.
REQ-004 SHALL have the outputs to ID/fetch:
- exe_ready  out  1  bundle accepted when high with id_valid.
- wb_result  out  ARQ  writeback data.
- wb_rd_out  out  4  destination register.
- wr_reg_en  out  1  one-cycle writeback strobe.
- branch_taken  out  1  one-cycle redirect strobe.
- jaddr_out  out  MEMORY_ADDR_SIZE  redirect target.
REQ-005 SHALL have the data-memory port:
- mem_req  out  1  request held until ack.
- mem_we  out  1  store when high.
- mem_addr  out  MEMORY_ADDR_SIZE  address.
- mem_wdata  out  ARQ  store data.
- mem_rdata  in  ARQ  load data.
- mem_ack  in  1  completion.
- mem_err  out  1  sticky timeout flag.

Function
REQ-006 SHALL implement FSM states IDLE, EXEC, MEM, WB; exe_ready SHALL be 1 only in IDLE.
REQ-007 SHALL, in IDLE with id_valid=1, register the whole bundle and go to EXEC; with id_valid=0 it SHALL stay in IDLE.
REQ-008 SHALL compute in EXEC: 00 A+B, 01 A-B, 10 low ARQ bits of A*B, 11 A^B; A=src1, B per mux_exe; overflow discarded modulo 2^ARQ.
REQ-009 SHALL, in EXEC with pc_en=0, return to IDLE with no memory access, no writeback and no redirect.
REQ-010 SHALL go from EXEC to MEM if rd_en or wr_en is set, otherwise to WB.
REQ-011 SHALL, in MEM, drive mem_req=1, mem_addr=ALU[MEMORY_ADDR_SIZE-1:0], mem_wdata=src3 and mem_we=wr_en; if both rd_en and wr_en are set the access is a store.
REQ-012 SHALL hold all MEM outputs stable until mem_ack, capture mem_rdata on the ack edge, then go to WB.
REQ-013 SHALL, in WB, pulse wr_reg_en for exactly one cycle when wb_en=1, with wb_result = mux_exe_mem ? captured rdata : ALU and wb_rd_out = registered rd; WB SHALL then go to IDLE.
REQ-014 SHALL, in WB, pulse branch_taken for exactly one cycle when jenable=1 and (jop_lsb=0 or ALU==0), with jaddr_out = registered jaddr.
REQ-015 SHALL meet these latencies: accept at edge N gives WB strobes in cycle N+2 with no memory access, or ack edge +1 with memory access.
REQ-016 SHALL hold wb_result, wb_rd_out and jaddr_out at their last values outside WB.

Reset
REQ-017 SHALL, on rst=0 asynchronously, force state IDLE and all outputs 0, including mem_err; an in-flight bundle is dropped.
REQ-018 SHALL leave IDLE no earlier than the first rising edge after rst deasserts.

Configuration
REQ-019 SHALL use macro MEM_TIMEOUT_EN:
- Defined: a 4-bit counter runs in MEM; after 15 cycles without mem_ack, mem_err is set sticky, captured rdata becomes 0, and the FSM goes to WB.
- Undefined: MEM waits indefinitely and mem_err is tied 0.

Verification
REQ-020 Reset mid-MEM: rst=0 -> same cycle mem_req=0 and exe_ready=0; after release, IDLE with exe_ready=1 and all outputs 0.
REQ-021 ALU: src1=17, imm=5, mux_exe=1, op 01, wb_en=1, rd=3 -> two cycles later wr_reg_en=1 for one cycle, wb_result=12, wb_rd_out=3.
REQ-022 Load: src1=0x0100, imm=4, op 00, rd_en=1, mux_exe_mem=1, ack after 3 cycles with rdata=0xBEEF -> mem_addr=0x104 held stable; wb_result=0xBEEF one cycle after ack.
REQ-023 Branch: src1=src2=9, op 01, jenable=1, jop_lsb=1, jaddr=0x1A0 -> branch_taken one cycle, jaddr_out=0x1A0; same with src2=8 -> no pulse.
REQ-024 Bubble: pc_en=0 with wb_en=1 and wr_en=1 -> no mem_req, no wr_reg_en, exe_ready high again after two cycles.
REQ-025 MEM_TIMEOUT_EN defined, mem_ack held 0 -> after 15 MEM cycles mem_err=1, wb_result=0; mem_err stays 1 until reset.
